// File: rtl/dmem_responder_if.sv
// Load/store port between the core's M stage (master) and the data memory
// responder (slave).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (output req, we, addr, wdata, be, input ready, rdata, rvalid, err);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata, rvalid, err);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// One access at a time; ready pulses for one cycle LATENCY cycles after
// acceptance. Word-addressed storage with byte enables.
// Optional feature macro: DMEM_ERR_EN (range/alignment error reporting).
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_we;

  logic [31:0] mem [DEPTH_WORDS];

  // Access being completed: when LATENCY=1 the response is entered straight
  // from IDLE, so the live request fields are used; otherwise the latched ones.
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_off;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;
  logic          acc_err;

  // Select live vs latched request fields and decode the word index
  always_comb begin
    if (state_q == IDLE) begin
      acc_we   = bus.we;
      acc_addr = bus.addr;
      acc_be   = bus.be;
    end else begin
      acc_we   = we_q;
      acc_addr = addr_q;
      acc_be   = be_q;
    end
    acc_off = acc_addr - BASE_ADDR;
    acc_idx = acc_off[AW+1:2];
  end

`ifdef DMEM_ERR_EN
  // Out of range, or misaligned with any byte lane enabled
  assign acc_err = (acc_off >= 32'(DEPTH_WORDS * 4)) ||
                   ((acc_addr[1:0] != 2'b00) && (acc_be != 4'b0000));
  logic unused_off;
  assign unused_off = ^acc_off[1:0];
`else
  // No checking: upper offset bits wrap, byte offset is ignored
  assign acc_err = 1'b0;
  logic unused_off;
  assign unused_off = ^{acc_off[31:AW+2], acc_off[1:0], acc_be};
`endif

  // Next-state, holding registers and response data
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        mem_we  = we_q & ~err_q;
      end
      default: state_d = IDLE;
    endcase
    // Response flags/data are registered on entry to RESP
    if (state_d == RESP && state_q != RESP) begin
      err_d    = acc_err;
      rvalid_d = ~acc_we;
      if (!acc_we) rdata_d = acc_err ? 32'h0 : mem[acc_idx];
    end
  end

  // State and response registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Store commit at the edge ending RESP; never cleared, reset blocks the write
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[acc_idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

  assign bus.ready  = (state_q == RESP);
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (target side) for the pipelined core's load/store port.
- Accepts one request at a time over a req/ready handshake and serves it after a programmable number of wait states.
- `ready` drives the core's memory-stage stall (`stall = req & ~ready`).
- Word-addressed storage with byte enables. Sits between the M-stage pipeline register outputs and the M/W pipeline register inputs.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, minimum 4.
- LATENCY, 2, cycles from request acceptance to the response cycle; range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- req  input  1  core requests an access; held high with all request fields stable until `ready`.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- wdata  input  32  store data.
- be  input  4  byte enables; be[i] covers wdata[8i+7:8i].
- ready  output  1  one-cycle response strobe; the access completes in this cycle.
- rdata  output  32  load data; valid when `ready & rvalid`.
- rvalid  output  1  high with `ready` for loads, low for stores.
- err  output  1  access error flag, qualified by `ready` (only with DMEM_ERR_EN).

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, ready=0, rvalid=0, err=0, rdata=0, wait counter=0.
  - Memory array is not cleared.
  - Reset overrides all other activity in that cycle.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if req=1, latch we/addr/wdata/be into holding registers and load counter=LATENCY-1. Go to RESP if LATENCY=1, otherwise WAIT. If req=0, stay in IDLE.
  - WAIT: decrement the counter each cycle. When the counter reads 1, go to RESP.
  - RESP: ready=1 for exactly this one cycle, then return to IDLE unconditionally.
- Latency: request sampled in IDLE at edge t → ready high in cycle t+LATENCY.
- Throughput: one access per LATENCY+1 cycles. A req still high in the cycle after RESP is treated as a new request.
- Address decode: offset = addr - BASE_ADDR; word index = offset[log2(DEPTH_WORDS)+1:2]. Use the latched address only; live `addr` is ignored after acceptance.
- Store: committed at the clk edge ending the RESP cycle. Only bytes with be[i]=1 are written; be=4'b0000 writes nothing but still completes with ready.
- Load: the full 32-bit word is read. `rdata` is registered, updates at entry to RESP, and holds its value until the next load response. `be` is ignored for loads.
- `rvalid` and `err` are registered alongside `ready` and are 0 whenever ready=0.
- req dropped while in WAIT: the access still completes (protocol violation, not an abort).
- Reset mid-operation (WAIT or RESP): the pending store is discarded, no memory write occurs, and the FSM returns to IDLE.
- Without DMEM_ERR_EN: out-of-range addresses wrap modulo DEPTH_WORDS (upper bits ignored), and addr[1:0] is ignored.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: an access is in error if offset >= DEPTH_WORDS*4, or if addr[1:0] != 0 while any be bit is set.
  - Errored access still completes with ready=1 at normal latency, with err=1.
  - Errored store writes nothing.
  - Errored load returns rdata=32'h0000_0000 with rvalid=1.
- Not defined: err is tied to 0, no range or alignment check is performed, and addresses wrap as described under Behaviour.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=1 → ready=0, rvalid=0, err=0, rdata=0 throughout; the first ready appears LATENCY cycles after the first edge with rst=1.
- Store then load, LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF (ready in cycle t+2); then load addr=0x10 → rdata=0xDEADBEEF, rvalid=1, ready high exactly 2 cycles after acceptance.
- Byte enables: preload 0x11223344 at 0x20; store wdata=0xAABBCCDD, be=4'b0101 → subsequent load returns 0x11BB33DD.
- Back-to-back: req held high for 3 loads with LATENCY=1 → ready pulses every 2nd cycle, exactly 3 pulses, `rdata` holds between pulses.
- Reset mid-store: accept store to 0x30 (old value 0x0), assert rst=0 in WAIT → no ready pulse; a later load of 0x30 returns 0x0.
- DMEM_ERR_EN, DEPTH_WORDS=1024:
  - Load addr=0x1000 → ready=1, err=1, rdata=0.
  - Store addr=0x22, be=4'hF → err=1, memory unchanged.
  - Without the macro, load addr=0x1000 returns the word at 0x0.
